// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between an instruction-fetch port (IF, read
// only) and a load/store port (DM). Only one access is outstanding at a time.
// A tie between the two ports in IDLE goes to the port that was not served
// last. After reset the last grant is IF, so DM wins the first tie.
// A granted access that sees no mem_ready for TIMEOUT busy cycles is aborted
// and reported to its requester with x_err=1.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          fetch request and word address (held until if_done)
//   if_done, if_rdata,       fetch completion pulse, read data, timeout flag
//   if_err
//   dm_req, dm_we, dm_addr,  load/store request (held until dm_done)
//   dm_wdata, dm_be
//   dm_done, dm_rdata,       load/store completion pulse, load data, timeout
//   dm_err
//   if_stall, dm_stall       pipeline hold: x_req & ~x_done
//   mem_req, mem_we,         memory request, driven from the registered fields
//   mem_addr, mem_wdata,     of the granted access
//   mem_be
//   mem_ready, mem_rdata     memory completion; rdata valid while ready=1
//
// TIMEOUT: maximum number of busy cycles without mem_ready, legal 1..255.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        dm_err,

  output logic        if_stall,
  output logic        dm_stall,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_t;

  // The abort fires on the busy cycle whose wait count is TIMEOUT-1, so the
  // access has spent exactly TIMEOUT busy cycles without mem_ready.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  grant_t      last_grant_q;
  logic [7:0]  wait_cnt_q;

  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic        if_done_q, if_err_q;
  logic [31:0] if_rdata_q;
  logic        dm_done_q, dm_err_q;
  logic [31:0] dm_rdata_q;

  logic        if_elig, dm_elig;
  logic        grant_if, grant_dm;
  logic        finish, abort;
  logic        busy;

  // A port in its done cycle is not eligible, so a requester that is slow to
  // drop req cannot be granted the same access twice.
  assign if_elig = if_req & ~if_done_q;
  assign dm_elig = dm_req & ~dm_done_q;
  assign busy    = (state_q != IDLE);

  // -------------------------------------------------------------------------
  // Next-state and grant/completion decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_elig && dm_elig) begin
          if (last_grant_q == GRANT_DM) grant_if = 1'b1;
          else                          grant_dm = 1'b1;
        end else if (if_elig) begin
          grant_if = 1'b1;
        end else if (dm_elig) begin
          grant_dm = 1'b1;
        end

        if (grant_if)      state_d = IF_BUSY;
        else if (grant_dm) state_d = DM_BUSY;
      end

      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt_q == LAST_WAIT) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and fairness pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      if (finish || abort)
        last_grant_q <= (state_q == DM_BUSY) ? GRANT_DM : GRANT_IF;
    end
  end

  // -------------------------------------------------------------------------
  // Request capture, wait counter and completion registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      // Done flags are one-cycle pulses unless a completion sets them below.
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;

      if (grant_if) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= 4'b1111;
        wait_cnt_q  <= '0;
      end else if (grant_dm) begin
        mem_we_q    <= dm_we;
        mem_addr_q  <= dm_addr;
        mem_wdata_q <= dm_wdata;
        mem_be_q    <= dm_be;
        wait_cnt_q  <= '0;
      end else if (busy && !mem_ready && !abort) begin
        wait_cnt_q  <= wait_cnt_q + 8'd1;
      end

      if (finish || abort) begin
        if (state_q == IF_BUSY) begin
          if_done_q  <= 1'b1;
          if_err_q   <= abort;
          if_rdata_q <= finish ? mem_rdata : 32'd0;
        end else begin
          dm_done_q  <= 1'b1;
          dm_err_q   <= abort;
          // Stores return no data.
          dm_rdata_q <= (finish && !mem_we_q) ? mem_rdata : 32'd0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_req   = busy;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_done   = dm_done_q;
  assign dm_err    = dm_err_q;
  assign dm_rdata  = dm_rdata_q;

  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

endmodule
